// File: rtl/input_debounce.sv
// Debounces one asynchronous input: a synchronizer chain feeding a four-state
// acceptance FSM, with registered level/edge/busy outputs and a glitch counter.
module input_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int COUNT_WIDTH     = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       signal_async,
    input  logic       glitch_clear,
    output logic       signal_stable,
    output logic       rise_pulse,
    output logic       fall_pulse,
    output logic       busy,
    output logic [7:0] glitch_count
);

    localparam logic [1:0] STABLE_LOW   = 2'd0;
    localparam logic [1:0] PENDING_HIGH = 2'd1;
    localparam logic [1:0] STABLE_HIGH  = 2'd2;
    localparam logic [1:0] PENDING_LOW  = 2'd3;

    localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] ONE_COUNT  = COUNT_WIDTH'(1);

    logic [SYNC_STAGES-1:0] sync_chain;
    logic                   sampled;
    logic [1:0]             state;
    logic [1:0]             state_next;
    logic [COUNT_WIDTH-1:0] count;
    logic [COUNT_WIDTH-1:0] count_next;
    logic                   abort;
    logic                   rise_next;
    logic                   fall_next;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_chain <= '0;
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], signal_async};
        end
    end

    assign sampled = sync_chain[SYNC_STAGES-1];

    // The first differing sample already counts as one; acceptance happens on
    // the DEBOUNCE_CYCLES-th consecutive differing sample.
    always_comb begin
        state_next = state;
        count_next = count;
        abort      = 1'b0;
        rise_next  = 1'b0;
        fall_next  = 1'b0;
        case (state)
            STABLE_LOW: begin
                if (sampled) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_next = STABLE_HIGH;
                        rise_next  = 1'b1;
                    end else begin
                        state_next = PENDING_HIGH;
                        count_next = ONE_COUNT;
                    end
                end
            end
            PENDING_HIGH: begin
                if (!sampled) begin
                    state_next = STABLE_LOW;
                    count_next = '0;
                    abort      = 1'b1;
                end else if (count >= LAST_COUNT) begin
                    state_next = STABLE_HIGH;
                    count_next = '0;
                    rise_next  = 1'b1;
                end else begin
                    count_next = count + ONE_COUNT;
                end
            end
            STABLE_HIGH: begin
                if (!sampled) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_next = STABLE_LOW;
                        fall_next  = 1'b1;
                    end else begin
                        state_next = PENDING_LOW;
                        count_next = ONE_COUNT;
                    end
                end
            end
            PENDING_LOW: begin
                if (sampled) begin
                    state_next = STABLE_HIGH;
                    count_next = '0;
                    abort      = 1'b1;
                end else if (count >= LAST_COUNT) begin
                    state_next = STABLE_LOW;
                    count_next = '0;
                    fall_next  = 1'b1;
                end else begin
                    count_next = count + ONE_COUNT;
                end
            end
            default: begin
                state_next = STABLE_LOW;
                count_next = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= STABLE_LOW;
            count         <= '0;
            signal_stable <= 1'b0;
            rise_pulse    <= 1'b0;
            fall_pulse    <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_next;
            count         <= count_next;
            signal_stable <= (state_next == STABLE_HIGH) || (state_next == PENDING_LOW);
            rise_pulse    <= rise_next;
            fall_pulse    <= fall_next;
            busy          <= (state_next == PENDING_HIGH) || (state_next == PENDING_LOW);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            glitch_count <= '0;
        end else if (glitch_clear) begin
            glitch_count <= '0;
        end else if (abort && (glitch_count != 8'hFF)) begin
            glitch_count <= glitch_count + 8'd1;
        end
    end

endmodule

// File: doc/input_debounce.md
INPUT_DEBOUNCE -- requirements
Module: input_debounce

Interface
REQ-001 SHALL provide parameter SYNC_STAGES, default 2, number of synchronizer flops (legal range 2..4).
REQ-002 SHALL provide parameter DEBOUNCE_CYCLES, default 1000, consecutive sampled cycles required to accept a level change (legal range 1..2^COUNT_WIDTH-1).
REQ-003 SHALL provide parameter COUNT_WIDTH, default 16, width of the debounce counter.
REQ-004 SHALL provide port clock  input  1  block clock; all state updates on rising edge.
REQ-005 SHALL provide port reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL provide port signal_async  input  1  raw asynchronous input (link/PHY pin, button).
REQ-007 SHALL provide port glitch_clear  input  1  synchronous clear of glitch_count.
REQ-008 SHALL provide port signal_stable  output  1  debounced level; drives the downstream edge detector.
REQ-009 SHALL provide port rise_pulse  output  1  one-cycle pulse when signal_stable goes 0->1.
REQ-010 SHALL provide port fall_pulse  output  1  one-cycle pulse when signal_stable goes 1->0.
REQ-011 SHALL provide port busy  output  1  high while a level change is pending.
REQ-012 SHALL provide port glitch_count  output  8  saturating count of aborted pending changes.

Function
REQ-013 SHALL pass signal_async through a SYNC_STAGES-deep flop chain; the last stage is the sampled value s.
REQ-014 SHALL implement FSM states STABLE_LOW, PENDING_HIGH, STABLE_HIGH, PENDING_LOW; signal_stable = 1 exactly in STABLE_HIGH and PENDING_LOW.
REQ-015 SHALL, in STABLE_LOW with s=1: go to PENDING_HIGH, counter=1 (or, if DEBOUNCE_CYCLES=1, go directly to STABLE_HIGH).
REQ-016 SHALL, in PENDING_HIGH with s=1 and counter<DEBOUNCE_CYCLES-1: increment counter, stay.
REQ-017 SHALL, in PENDING_HIGH with s=1 and counter=DEBOUNCE_CYCLES-1: go to STABLE_HIGH, counter=0, assert rise_pulse in the following cycle only.
REQ-018 SHALL, in PENDING_HIGH with s=0: return to STABLE_LOW, counter=0, increment glitch_count; no pulse.
REQ-019 SHALL treat STABLE_HIGH/PENDING_LOW symmetrically with s inverted, asserting fall_pulse on acceptance.
REQ-020 SHALL register signal_stable, rise_pulse, fall_pulse, busy; busy = 1 exactly in PENDING_* states.
REQ-021 SHALL yield total latency from a clean signal_async change to signal_stable change of SYNC_STAGES+DEBOUNCE_CYCLES clock edges.
REQ-022 SHALL never assert rise_pulse and fall_pulse in the same cycle; pulses coincide with the first cycle of the new signal_stable value.
REQ-023 SHALL saturate glitch_count at 255 (no wrap).
REQ-024 SHALL, when glitch_clear=1 at an edge, set glitch_count=0; clear wins over a simultaneous abort increment.
REQ-025 SHALL never let the counter exceed DEBOUNCE_CYCLES-1 nor wrap.

Reset
REQ-026 SHALL, on reset assertion, immediately force: synchronizer flops 0, state STABLE_LOW, counter 0, signal_stable 0, rise_pulse 0, fall_pulse 0, busy 0, glitch_count 0.
REQ-027 SHALL abandon any pending change on reset mid-operation without asserting a pulse or incrementing glitch_count.
REQ-028 SHALL, after reset release with signal_async held high, accept the high level via the normal PENDING_HIGH path (rise_pulse asserted once).

Verification (SYNC_STAGES=2, DEBOUNCE_CYCLES=4)
REQ-029 SHALL cover: signal_async 0->1 after edge 0, held -> signal_stable=1 after edge 6, rise_pulse high for exactly that one cycle, busy high after edges 3..5.
REQ-030 SHALL cover: high pulse of 3 cycles on signal_async from STABLE_LOW -> signal_stable stays 0, no rise_pulse, glitch_count=1.
REQ-031 SHALL cover: 300 aborted 2-cycle glitches -> glitch_count=255; then glitch_clear coinciding with an abort -> glitch_count=0.
REQ-032 SHALL cover: stable high then signal_async 1->0 held -> fall_pulse one cycle, signal_stable=0 after 6 edges.
REQ-033 SHALL cover: reset asserted at counter=2 in PENDING_HIGH -> all outputs 0 asynchronously, no pulse, glitch_count unchanged at 0.
REQ-034 SHALL cover: DEBOUNCE_CYCLES=1 build -> change visible after 3 edges, single pulse.
